// File: rtl/adpll_loop_ctrl.sv
// adpll_loop_ctrl: ADPLL digital loop controller. Integrates synchronized PFD UP/DN votes
// over fixed windows and steers the DCO word through acquisition, tracking and lock.

// Two-flop synchronizer cell, one per asynchronous PFD flag.
module adpll_sync2 (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module adpll_loop_ctrl #(
  parameter int CW        = 8,
  parameter int WIN_LOG2  = 4,
  parameter int CODE_INIT = 128,
  parameter int DEADBAND  = 1,
  parameter int LOSS_TH   = 8,
  parameter int LOCK_WIN  = 4
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          EN,
  input  logic          UP,
  input  logic          DN,
  output logic [CW-1:0] DCO_CODE,
  output logic          LOCKED,
  output logic [1:0]    STATE,
  output logic          WIN_DONE
);
  localparam int NW  = WIN_LOG2 + 2;
  localparam int LCW = $clog2(LOCK_WIN + 1);

  localparam logic [CW-1:0]  CODE_RST  = CW'(CODE_INIT);
  localparam logic [CW-1:0]  STEP_RST  = CW'(1) << (CW - 2);
  localparam logic [CW-1:0]  STEP_ONE  = CW'(1);
  localparam logic [NW-1:0]  DB_V      = NW'(DEADBAND);
  localparam logic [NW-1:0]  LOSS_V    = NW'(LOSS_TH);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_WIN - 1);

  typedef enum logic [1:0] {
    ST_ACQ   = 2'd0,
    ST_TRACK = 2'd1,
    ST_LOCK  = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         code_q, code_d;
  logic [CW-1:0]         step_q, step_d;
  logic [LCW-1:0]        lc_q, lc_d;
  logic                  lastv_q, lastv_d;
  logic                  lastdir_q, lastdir_d;
  logic                  locked_q, locked_d;
  logic                  wd_q;
  logic [WIN_LOG2-1:0]   cnt_q;
  logic signed [NW-1:0]  net_q;

  logic                  ups, dns;
  logic signed [NW-1:0]  vote, net_full;
  logic [NW-1:0]         mag;
  logic                  dir_up, eval, rev;
  logic [CW-1:0]         step_h;

  // UP/DN are asynchronous; bit 0 = UP, bit 1 = DN.
  adpll_sync2 u_sync [1:0] (
    .gclk   (CLK),
    .grst_n (RESET_N),
    .d      ({DN, UP}),
    .q      ({dns, ups})
  );

  function automatic logic [CW-1:0] sat_mv(input logic [CW-1:0] c,
                                           input logic [CW-1:0] s,
                                           input logic          up);
    logic [CW:0] sum;
    sum = {1'b0, c} + {1'b0, s};
    if (up) return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
    return (s > c) ? '0 : c - s;
  endfunction

  always_comb begin
    vote = '0;
    if (ups && !dns)      vote = NW'(1);
    else if (dns && !ups) vote = '1;
    // The evaluating cycle's own vote is folded in before judging the window.
    net_full = net_q + vote;
    mag      = net_full[NW-1] ? NW'(-net_full) : NW'(net_full);
    dir_up   = !net_full[NW-1];
    eval     = EN && (cnt_q == '1);
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    step_d    = step_q;
    lc_d      = lc_q;
    lastv_d   = lastv_q;
    lastdir_d = lastdir_q;
    locked_d  = locked_q;
    rev       = 1'b0;
    step_h    = step_q;
    if (state_q == ST_BAD) begin
      state_d  = ST_ACQ;
      locked_d = 1'b0;
    end else if (eval) begin
      case (state_q)
        ST_ACQ: begin
          if (mag > DB_V) begin
            rev       = lastv_q && (lastdir_q != dir_up);
            lastv_d   = 1'b1;
            lastdir_d = dir_up;
            if (rev && step_q == STEP_ONE) begin
              state_d = ST_TRACK;
              code_d  = sat_mv(code_q, STEP_ONE, dir_up);
              lc_d    = '0;
            end else begin
              step_h = rev ? (step_q >> 1) : step_q;
              step_d = step_h;
              code_d = sat_mv(code_q, step_h, dir_up);
            end
          end
        end
        ST_TRACK: begin
          if (mag > DB_V) begin
            code_d = sat_mv(code_q, STEP_ONE, dir_up);
            lc_d   = '0;
          end else begin
            lc_d = lc_q + LCW'(1);
            if (lc_q == LOCK_LAST) begin
              state_d  = ST_LOCK;
              locked_d = 1'b1;
            end
          end
        end
        ST_LOCK: begin
          if (mag > LOSS_V) begin
            state_d  = ST_TRACK;
            locked_d = 1'b0;
            code_d   = sat_mv(code_q, STEP_ONE, dir_up);
            lc_d     = '0;
          end else if (mag > DB_V) begin
            code_d = sat_mv(code_q, STEP_ONE, dir_up);
          end
        end
        default: state_d = ST_ACQ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= ST_ACQ;
      code_q    <= CODE_RST;
      step_q    <= STEP_RST;
      lc_q      <= '0;
      lastv_q   <= 1'b0;
      lastdir_q <= 1'b0;
      locked_q  <= 1'b0;
      wd_q      <= 1'b0;
      cnt_q     <= '0;
      net_q     <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      step_q    <= step_d;
      lc_q      <= lc_d;
      lastv_q   <= lastv_d;
      lastdir_q <= lastdir_d;
      locked_q  <= locked_d;
      wd_q      <= eval;
      if (EN) begin
        if (eval) begin
          cnt_q <= '0;
          net_q <= '0;
        end else begin
          cnt_q <= cnt_q + WIN_LOG2'(1);
          net_q <= net_full;
        end
      end
    end
  end

  assign DCO_CODE = code_q;
  assign LOCKED   = locked_q;
  assign STATE    = state_q;
  assign WIN_DONE = wd_q;
endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// tb_adpll_loop_ctrl: directed and randomized checks of adpll_loop_ctrl against a
// window-level behavioural model of the loop rules.
module tb_adpll_loop_ctrl;
  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       EN = 1'b0;
  logic       UP = 1'b0;
  logic       DN = 1'b0;
  logic [7:0] DCO_CODE;
  logic       LOCKED;
  logic [1:0] STATE;
  logic       WIN_DONE;

  int checks = 0;
  int failures = 0;

  adpll_loop_ctrl dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .EN       (EN),
    .UP       (UP),
    .DN       (DN),
    .DCO_CODE (DCO_CODE),
    .LOCKED   (LOCKED),
    .STATE    (STATE),
    .WIN_DONE (WIN_DONE)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain integers, window sums, 2-cycle input delay line.
  int m_code, m_state, m_step, m_lc, m_net, m_cnt, m_lastdir;
  bit m_lastv, m_locked, m_wd;
  bit [1:0] hu, hd;

  function automatic int sat(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  task automatic m_eval();
    int mag, dir;
    mag = (m_net < 0) ? -m_net : m_net;
    dir = (m_net > 0) ? 1 : -1;
    case (m_state)
      0: if (mag > 1) begin
        if (m_lastv && dir != m_lastdir) begin
          if (m_step == 1) begin
            m_state = 1; m_code = sat(m_code + dir); m_lc = 0;
          end else begin
            m_step = m_step / 2; m_code = sat(m_code + dir * m_step);
          end
        end else m_code = sat(m_code + dir * m_step);
        m_lastv = 1; m_lastdir = dir;
      end
      1: if (mag > 1) begin
        m_code = sat(m_code + dir); m_lc = 0;
      end else begin
        m_lc++;
        if (m_lc == 4) begin m_state = 2; m_locked = 1; end
      end
      2: if (mag > 8) begin
        m_state = 1; m_locked = 0; m_code = sat(m_code + dir); m_lc = 0;
      end else if (mag > 1) m_code = sat(m_code + dir);
      default: m_state = 0;
    endcase
  endtask

  task automatic m_clock(input bit rst_n, input bit en, input bit up, input bit dn);
    bit vu, vd;
    if (!rst_n) begin
      m_code = 128; m_state = 0; m_step = 64; m_lc = 0; m_net = 0; m_cnt = 0;
      m_lastv = 0; m_lastdir = 0; m_locked = 0; m_wd = 0; hu = '0; hd = '0;
    end else begin
      vu = hu[1]; vd = hd[1];
      m_wd = 0;
      if (en) begin
        if (vu && !vd) m_net++;
        else if (vd && !vu) m_net--;
        m_cnt++;
        if (m_cnt == 16) begin
          m_eval(); m_wd = 1; m_cnt = 0; m_net = 0;
        end
      end
      hu = {hu[0], up}; hd = {hd[0], dn};
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit rst_n, input bit en, input bit up, input bit dn);
    @(negedge CLK);
    RESET_N = rst_n; EN = en; UP = up; DN = dn;
    @(posedge CLK);
    m_clock(rst_n, en, up, dn);
    #1;
    chk("code", DCO_CODE, m_code);
    chk("state", STATE, m_state);
    chk("locked", LOCKED, m_locked);
    chk("win_done", WIN_DONE, m_wd);
  endtask

  task automatic win(input bit up, input bit dn);
    repeat (16) cyc(1, 1, up, dn);
  endtask

  task automatic do_reset();
    repeat (3) cyc(0, 1, 1, 0);
  endtask

  int bs_exp[8] = '{192, 160, 176, 168, 172, 170, 171, 170};
  bit bs_up[8]  = '{1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    // Reset with UP held high, then first window timing.
    do_reset();
    chk("rst_code", DCO_CODE, 128);
    chk("rst_state", STATE, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_wd", WIN_DONE, 0);
    repeat (15) cyc(1, 1, 1, 0);
    chk("first_wd_early", WIN_DONE, 0);
    cyc(1, 1, 1, 0);
    chk("first_wd", WIN_DONE, 1);
    chk("acq_192", DCO_CODE, 192);
    win(1, 0);
    chk("acq_sat", DCO_CODE, 255);
    win(1, 0);
    chk("acq_sat_hold", DCO_CODE, 255);
    chk("acq_sat_state", STATE, 0);

    // Binary search with alternating windows down to a step-1 reversal.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      win(bs_up[i], !bs_up[i]);
      chk("bsearch", DCO_CODE, bs_exp[i]);
    end
    chk("bs_track", STATE, 1);

    // Lock: first quiet window still sees the DN tail, then four in-band windows.
    win(0, 0);
    chk("trk_tail", DCO_CODE, 169);
    repeat (3) win(0, 0);
    chk("no_lock_yet", STATE, 1);
    win(0, 0);
    chk("lock_state", STATE, 2);
    chk("lock_flag", LOCKED, 1);

    // Moderate error stays locked, large error drops to TRACK.
    repeat (5) cyc(1, 1, 1, 0);
    repeat (11) cyc(1, 1, 0, 0);
    chk("lock_small", DCO_CODE, 170);
    chk("lock_small_flag", LOCKED, 1);
    win(1, 0);
    chk("loss_state", STATE, 1);
    chk("loss_flag", LOCKED, 0);
    chk("loss_code", DCO_CODE, 171);

    // Three in-band windows then an UP window: counter cleared, no lock.
    win(0, 0);
    repeat (3) win(0, 0);
    win(1, 0);
    chk("pre_lock_break", STATE, 1);
    chk("pre_lock_code", DCO_CODE, 173);

    // Simultaneous UP/DN window.
    win(1, 1);
    win(1, 1);
    chk("both_hold", DCO_CODE, 174);

    // EN low mid-window with UP toggling.
    repeat (8) cyc(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, i[0], 0);
    chk("en_freeze_code", DCO_CODE, 174);
    repeat (8) cyc(1, 1, 0, 0);
    chk("en_resume_wd", WIN_DONE, 1);
    chk("en_resume_code", DCO_CODE, 174);

    // Reset mid-window.
    repeat (7) cyc(1, 1, 1, 0);
    cyc(0, 1, 1, 0);
    chk("midrst_code", DCO_CODE, 128);
    chk("midrst_state", STATE, 0);
    chk("midrst_wd", WIN_DONE, 0);
    chk("midrst_locked", LOCKED, 0);

    // Randomized windows with biased modes, EN gaps and rare resets.
    for (int w = 0; w < 120; w++) begin
      int mode;
      mode = $urandom_range(0, 4);
      for (int c = 0; c < 16; c++) begin
        bit en, up, dn, rn;
        rn = ($urandom_range(0, 399) != 0);
        en = ($urandom_range(0, 9) != 0);
        case (mode)
          0: begin up = ($urandom_range(0, 7) != 0); dn = ($urandom_range(0, 7) == 0); end
          1: begin dn = ($urandom_range(0, 7) != 0); up = ($urandom_range(0, 7) == 0); end
          2: begin up = $urandom_range(0, 1); dn = $urandom_range(0, 1); end
          3: begin up = 0; dn = 0; end
          default: begin up = ($urandom_range(0, 3) == 0); dn = 0; end
        endcase
        cyc(rn, en, up, dn);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
